core_datapath_mc: RTL
=====================

// Module: core_datapath_mc
// PURPOSE
//  Multi-cycle successor of the single-cycle RV32I datapath. It keeps the same external decoder interface
//  (result_src, pc_src, alu_src, reg_write, imm_src, alu_control) and adds an internal phase FSM.
//  Instruction and data traffic share one memory port with a req/ready handshake, so memory may stall for
//  any number of cycles. It sits between the main decoder/ALU decoder and a unified memory.
// PARAMETERS
//  XLEN      32     datapath width; only 32 is legal in this generation (elaboration $error otherwise)
//  RESET_PC  32'h0  PC value loaded on reset
//  NREGS     32     architectural registers; x0 is hard-wired to 0
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     synchronous, active-high
//  result_src   in   2     00 ALUOut, 01 load data, 10 OldPC+4
//  pc_src       in   1     1 = take PCtarget; sampled in EXEC
//  alu_src      in   1     0 = rs2 register, 1 = ImmExt
//  reg_write    in   1     write rd in WB
//  mem_write    in   1     instruction is a store
//  imm_src      in   2     immediate format for the extend block
//  alu_control  in   4     ALU operation
//  instr        out  32    latched instruction register (IR); drives the decoder
//  zero         out  1     ALU zero flag (combinational from EXEC operands)
//  PC           out  XLEN  current-instruction PC register
//  mem_req      out  1     memory access request
//  mem_we       out  1     write strobe, qualified by mem_req
//  mem_addr     out  XLEN  access address
//  mem_wdata    out  XLEN  store data
//  mem_rdata    in   XLEN  read data, valid while mem_ready=1
//  mem_ready    in   1     access completes on a cycle where mem_req && mem_ready
//  retire       out  1     one-cycle pulse when an instruction completes
// BEHAVIOUR
//  Reset values: state=FETCH, PC=RESET_PC, IR=32'h00000013 (NOP), OldPC/A/B/ALUOut/Data=0,
//   pc_src_q=0, retire=0, mem_req=0 during the reset cycle.
//  Reset mid-operation: aborts any access. mem_req drops in the cycle reset is high; the register file is not cleared.
//  FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready: IR<=mem_rdata, OldPC<=PC, then DECODE.
//  DECODE: A<=RF[rs1], B<=RF[rs2], then EXEC. Exactly one cycle.
//  EXEC: ALU(A, alu_src?ImmExt:B); ALUOut<=result; pc_src_q<=pc_src.
//   Next state: MEM if mem_write or result_src==01; otherwise WB.
//  MEM: mem_req=1, mem_addr=ALUOut, mem_we=mem_write, mem_wdata=B.
//   On ready for a load: Data<=mem_rdata, then WB.
//   On ready for a store: commit, then FETCH.
//  WB: if reg_write && rd!=0, RF[rd]<=Result (mux per result_src); commit, then FETCH.
//  Commit: PC <= pc_src_q ? OldPC+ImmExt : OldPC+4, and retire=1 for that one cycle.
//  Handshake: while mem_req=1 without ready, mem_addr, mem_we and mem_wdata hold stable. The FSM does not
//   advance. ready while mem_req=0 is ignored.
//  Arithmetic: all adds wrap modulo 2^XLEN. PC=32'hFFFFFFFC with pc_src_q=0 commits PC=0.
//  Latency: ALU/jump 4 cycles, store 4, load 5, each plus memory wait cycles. retire never fires in
//   consecutive cycles.
//  Register writes in WB are visible to the next instruction's DECODE (no forwarding needed).
// STRUCTURE
//  Package core_mc_pkg: state enum {FETCH, DECODE, EXEC, MEM, WB}; result_src encodings RES_ALU/RES_MEM/RES_PC4;
//   NOP constant 32'h00000013.
//  Reuses the existing extend and alu blocks.
//  One new sub-module: core_regfile_p (XLEN, NREGS; 2 async read ports, 1 sync write port, x0=0).
//  FSM, non-architectural registers and muxes stay inline.
// TESTING
//  1 reset -> PC=RESET_PC, mem_req=0, retire=0. First cycle after reset: mem_req=1, mem_addr=RESET_PC, mem_we=0.
//  2 addi x1,x0,5 (32'h00500093), ready with no wait -> retire exactly 4 cycles after fetch start, x1=5, PC+=4.
//  3 sw x1,8(x0) with ready held low 3 cycles -> mem_addr=8, mem_wdata=5, mem_we=1 stable all 4 cycles,
//    retire 7 cycles after fetch start.
//  4 lw x2,8(x0), memory returns 32'hDEADBEEF -> x2=32'hDEADBEEF, retire 5 cycles after fetch start.
//    A following add x3,x2,x0 reads 32'hDEADBEEF.
//  5 beq x0,x0,-8 at PC=0x100 (pc_src=1) -> next fetch at 0xF8. Same branch with pc_src=0 -> next fetch at 0x104.
//  6 reset asserted during a MEM stall of a store -> mem_req=0 that cycle, no write performed,
//    next fetch at RESET_PC. addi x0,x0,7 -> x0 reads 0.

Source files
------------

// File: rtl/core_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I datapath.
// Contents:
//   - the phase FSM state type
//   - result_src, imm_src and alu_control encodings
//   - the NOP instruction word
//   - the immediate-extend and ALU blocks, written as pure functions
package core_mc_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sign-extended immediate for the I/S/B/J instruction formats.
    function automatic logic [31:0] imm_extend(input logic [31:0] ir, input logic [1:0] sel);
        logic [31:0] imm;
        unique case (sel)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = 32'($signed(a) < $signed(b));
            ALU_SLTU: y = 32'(a < b);
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            default:  y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/core_datapath_mc_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// Signals:
//   req    access request
//   we     write strobe, qualified by req
//   addr   access address
//   wdata  store data
//   rdata  read data, valid while ready=1
//   ready  the access completes on a cycle where req && ready
// Modports:
//   master  core side
//   slave   memory side
interface core_datapath_mc_if #(parameter int XLEN = 32);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/core_regfile_p.sv
// Architectural register file.
// Ports:
//   clk       write clock
//   ra1, ra2  asynchronous read addresses
//   rd1, rd2  asynchronous read data
//   wa        synchronous write address
//   we        write enable
//   wd        write data
// Register 0 always reads as zero and ignores writes.
module core_regfile_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    input  logic [RAW-1:0]  wa,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREGS];

    // NOTE: the array has no reset; it maps onto plain RAM/flops and software never relies on initial contents.
    always_ff @(posedge clk) begin
        if (we && wa != '0) regs[wa] <= wd;
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/core_datapath_mc.sv
// Multi-cycle RV32I datapath: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Instruction and data accesses share one memory port.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   result_src, pc_src, alu_src, reg_write, mem_write, imm_src, alu_control
//               control inputs from the main/ALU decoder
//   instr       latched instruction register feeding the decoder
//   zero        ALU zero flag
//   PC          PC of the current instruction
//   mem         unified memory port (master side)
//   retire      one-cycle pulse, registered, after an instruction commits
module core_datapath_mc import core_mc_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                result_src,
    input  logic                      pc_src,
    input  logic                      alu_src,
    input  logic                      reg_write,
    input  logic                      mem_write,
    input  logic [1:0]                imm_src,
    input  logic [3:0]                alu_control,
    output logic [31:0]               instr,
    output logic                      zero,
    output logic [XLEN-1:0]           PC,
    core_datapath_mc_if.master        mem,
    output logic                      retire
);
    localparam int RAW = $clog2(NREGS);

    if (XLEN != 32) begin : g_xlen_check
        $error("core_datapath_mc: only XLEN=32 is supported");
    end

    state_t          state, state_next;
    logic [31:0]     ir;
    logic [XLEN-1:0] old_pc, a_q, b_q, alu_out, data_q;
    logic            pc_src_q, retire_q, commit, rf_we;
    logic [XLEN-1:0] imm_ext, src_b, alu_result, rd1, rd2, result, pc_plus4, pc_target;

    // Immediate and branch target come from the held IR, so they are valid in every phase.
    assign imm_ext    = imm_extend(ir, imm_src);
    assign src_b      = alu_src ? imm_ext : b_q;
    assign alu_result = alu_fn(alu_control, a_q, src_b);
    assign zero       = (alu_result == '0);
    assign pc_plus4   = old_pc + XLEN'(4);
    assign pc_target  = old_pc + imm_ext;

    always_comb begin
        case (result_src)
            RES_MEM: result = data_q;
            RES_PC4: result = pc_plus4;
            default: result = alu_out;
        endcase
    end

    core_regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk (clk),
        .ra1 (ir[15 +: RAW]),
        .ra2 (ir[20 +: RAW]),
        .wa  (ir[7 +: RAW]),
        .we  (rf_we),
        .wd  (result),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // Next state and memory port. Reset forces the port idle in the same
    // cycle so an in-flight access is abandoned rather than completed.
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        mem.req    = 1'b0;
        mem.we     = 1'b0;
        mem.addr   = PC;
        mem.wdata  = b_q;
        commit     = 1'b0;
        rf_we      = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    mem.req = 1'b1;
                    if (mem.ready) state_next = DECODE;
                end
                DECODE: state_next = EXEC;
                EXEC:   state_next = (mem_write || result_src == RES_MEM) ? MEM : WB;
                MEM: begin
                    mem.req  = 1'b1;
                    mem.addr = alu_out;
                    mem.we   = mem_write;
                    if (mem.ready) begin
                        commit     = mem_write;
                        state_next = mem_write ? FETCH : WB;
                    end
                end
                WB: begin
                    rf_we      = reg_write;
                    commit     = 1'b1;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            PC       <= RESET_PC;
            ir       <= NOP_INSTR;
            old_pc   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_out  <= '0;
            data_q   <= '0;
            pc_src_q <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state    <= state_next;
            retire_q <= commit;
            case (state)
                FETCH: if (mem.ready) begin
                    ir     <= mem.rdata;
                    old_pc <= PC;
                end
                DECODE: begin
                    a_q <= rd1;
                    b_q <= rd2;
                end
                EXEC: begin
                    alu_out  <= alu_result;
                    pc_src_q <= pc_src;
                end
                MEM: if (mem.ready && !mem_write) data_q <= mem.rdata;
                default: ;
            endcase
            if (commit) PC <= pc_src_q ? pc_target : pc_plus4;
        end
    end

    assign instr  = ir;
    assign retire = retire_q;
endmodule
